// File: rtl/multicycle_ctrl.sv
// Control sequencer for the multi-cycle CPU datapath: steps each instruction through
// fetch/decode/execute/memory/writeback, owns the memory handshake and counts retirements.
module multicycle_ctrl #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             i_clk,
    input  logic             i_reset,       // active-low, asynchronous
    input  logic             i_run,
    input  logic [3:0]       i_opcode,
    input  logic             i_zero,
    input  logic             i_mem_ready,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic             o_addr_sel,
    output logic             o_ir_we,
    output logic             o_pc_we,
    output logic             o_rf_we,
    output logic [1:0]       o_pc_src,
    output logic [1:0]       o_alu_src_b,
    output logic [1:0]       o_alu_op,
    output logic             o_wb_sel,
    output logic [3:0]       o_state,
    output logic             o_halted,
    output logic             o_fault,
    output logic [1:0]       o_fault_code,
    output logic [CNT_W-1:0] o_retired
);

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StExec   = 4'd3,
        StAluWb  = 4'd4,
        StAddr   = 4'd5,
        StMemRd  = 4'd6,
        StMemWb  = 4'd7,
        StMemWr  = 4'd8,
        StBranch = 4'd9,
        StJump   = 4'd10,
        StHalt   = 4'd11,
        StErr    = 4'd12
    } state_e;

    localparam logic [3:0] OpAluR  = 4'h0;
    localparam logic [3:0] OpAluI  = 4'h1;
    localparam logic [3:0] OpLoad  = 4'h2;
    localparam logic [3:0] OpStore = 4'h3;
    localparam logic [3:0] OpBeq   = 4'h4;
    localparam logic [3:0] OpJump  = 4'h5;
    localparam logic [3:0] OpHalt  = 4'hF;

    // Last wait cycle: a still-low mem_ready here means the access has timed out.
    localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

    state_e           r_state;
    state_e           w_next_state;
    logic [7:0]       r_wait;
    logic [1:0]       r_fault_code;
    logic [1:0]       w_fault_code_d;
    logic [CNT_W-1:0] r_retired;
    logic             w_retire;
    logic             w_wait_state;
    logic             w_wait_hit;

    assign w_wait_hit = (r_wait == WaitLast);

    always_comb begin
        w_next_state   = r_state;
        w_fault_code_d = r_fault_code;
        w_retire       = 1'b0;
        w_wait_state   = 1'b0;
        o_mem_req      = 1'b0;
        o_mem_we       = 1'b0;
        o_addr_sel     = 1'b0;
        o_ir_we        = 1'b0;
        o_pc_we        = 1'b0;
        o_rf_we        = 1'b0;
        o_pc_src       = 2'd0;
        o_alu_src_b    = 2'd0;
        o_alu_op       = 2'd0;
        o_wb_sel       = 1'b0;

        case (r_state)
            StIdle: begin
                if (i_run) w_next_state = StFetch;
            end
            StFetch: begin
                w_wait_state = 1'b1;
                o_mem_req    = 1'b1;
                o_alu_src_b  = 2'd2;
                if (i_mem_ready) begin
                    o_ir_we      = 1'b1;
                    o_pc_we      = 1'b1;
                    w_next_state = StDecode;
                end else if (w_wait_hit) begin
                    w_next_state   = StErr;
                    w_fault_code_d = 2'd2;
                end
            end
            StDecode: begin
                o_alu_src_b = 2'd1;
                case (i_opcode)
                    OpAluR, OpAluI:  w_next_state = StExec;
                    OpLoad, OpStore: w_next_state = StAddr;
                    OpBeq:           w_next_state = StBranch;
                    OpJump:          w_next_state = StJump;
                    OpHalt:          w_next_state = StHalt;
                    default: begin
                        w_next_state   = StErr;
                        w_fault_code_d = 2'd1;
                    end
                endcase
            end
            StExec: begin
                o_alu_op     = 2'd2;
                o_alu_src_b  = (i_opcode == OpAluI) ? 2'd1 : 2'd0;
                w_next_state = StAluWb;
            end
            StAluWb: begin
                o_rf_we      = 1'b1;
                w_retire     = 1'b1;
                w_next_state = StFetch;
            end
            StAddr: begin
                o_alu_src_b  = 2'd1;
                w_next_state = (i_opcode == OpLoad) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                w_wait_state = 1'b1;
                o_mem_req    = 1'b1;
                o_addr_sel   = 1'b1;
                if (i_mem_ready) begin
                    w_next_state = StMemWb;
                end else if (w_wait_hit) begin
                    w_next_state   = StErr;
                    w_fault_code_d = 2'd2;
                end
            end
            StMemWb: begin
                o_rf_we      = 1'b1;
                o_wb_sel     = 1'b1;
                w_retire     = 1'b1;
                w_next_state = StFetch;
            end
            StMemWr: begin
                w_wait_state = 1'b1;
                o_mem_req    = 1'b1;
                o_mem_we     = 1'b1;
                o_addr_sel   = 1'b1;
                if (i_mem_ready) begin
                    w_retire     = 1'b1;
                    w_next_state = StFetch;
                end else if (w_wait_hit) begin
                    w_next_state   = StErr;
                    w_fault_code_d = 2'd2;
                end
            end
            StBranch: begin
                o_alu_op     = 2'd1;
                o_pc_we      = i_zero;
                o_pc_src     = 2'd1;
                w_retire     = 1'b1;
                w_next_state = StFetch;
            end
            StJump: begin
                o_pc_we      = 1'b1;
                o_pc_src     = 2'd2;
                w_retire     = 1'b1;
                w_next_state = StFetch;
            end
            StHalt, StErr: begin
                w_next_state = r_state;
            end
            default: begin
                w_next_state = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= StIdle;
            r_wait       <= 8'd0;
            r_fault_code <= 2'd0;
            r_retired    <= '0;
        end else begin
            r_state      <= w_next_state;
            r_fault_code <= w_fault_code_d;
            // Counts only while a wait state keeps stalling; any completion or move clears it.
            if (w_wait_state && !i_mem_ready && (w_next_state == r_state)) begin
                r_wait <= r_wait + 8'd1;
            end else begin
                r_wait <= 8'd0;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign o_state      = r_state;
    assign o_halted     = (r_state == StHalt);
    assign o_fault      = (r_state == StErr);
    assign o_fault_code = r_fault_code;
    assign o_retired    = r_retired;

endmodule
